cacheline_burst_adapter: RTL

- Memory-side responder for the data/instruction cache controllers. It sits between the cache's line-level fill/writeback port and the burst DRAM port.
- It accepts a full-line read (ALLOCATE) or write (WRITEBACK) and converts it into a fixed-length burst of narrow beats. Read beats are reassembled into a line.
- It returns a single-cycle dfp_resp to the cache when the transaction completes.
- Line geometry matches the cache address split: 32-byte line, 5-bit offset.

---
 rtl/cacheline_burst_adapter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/cacheline_burst_adapter.sv
// cacheline_burst_adapter
//
// Memory-side responder for the cache fill/writeback port. A full-line read
// (allocate) becomes one burst read command plus BURST_LEN collected beats
// assembled into a line. A full-line write (writeback) becomes BURST_LEN
// write beats. Completion is signalled to the cache with a one-cycle dfp_resp.
// Every output is driven straight from a flop.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   dfp_addr_i         cache line address (offset bits ignored)
//   dfp_read_i         line read request, held until dfp_resp_o
//   dfp_write_i        line write request, held until dfp_resp_o
//   dfp_wdata_i        writeback line
//   dfp_rdata_o        last assembled fill line
//   dfp_resp_o         one-cycle completion pulse
//   bmem_addr_o        line-aligned burst address
//   bmem_read_o        burst read command
//   bmem_write_o       write beat valid
//   bmem_wdata_o       write beat data
//   bmem_ready_i       memory accepts command/beat this cycle
//   bmem_rdata_i       read beat data
//   bmem_rvalid_i      read beat valid
//   proto_err_o        sticky: read beat seen outside read collection
module cacheline_burst_adapter #(
    parameter int unsigned BEAT_W    = 64,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [31:0]                 dfp_addr_i,
    input  logic                        dfp_read_i,
    input  logic                        dfp_write_i,
    input  logic [BEAT_W*BURST_LEN-1:0] dfp_wdata_i,
    output logic [BEAT_W*BURST_LEN-1:0] dfp_rdata_o,
    output logic                        dfp_resp_o,
    output logic [31:0]                 bmem_addr_o,
    output logic                        bmem_read_o,
    output logic                        bmem_write_o,
    output logic [BEAT_W-1:0]           bmem_wdata_o,
    input  logic                        bmem_ready_i,
    input  logic [BEAT_W-1:0]           bmem_rdata_i,
    input  logic                        bmem_rvalid_i,
    output logic                        proto_err_o
);

    localparam int unsigned LINE_W   = BEAT_W * BURST_LEN;
    localparam int unsigned OFFSET_W = $clog2(LINE_W / 8);
    localparam int unsigned CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdCmd,
        StRdCollect,
        StWrBurst,
        StResp
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [LINE_W-1:0]  line_q, line_d;     // shared fill / writeback buffer
    logic [LINE_W-1:0]  rdata_q, rdata_d;
    logic               resp_q, resp_d;
    logic [31:0]        addr_q, addr_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [BEAT_W-1:0]  wdata_q, wdata_d;
    logic               err_q, err_d;

    logic [31:0]        cur_base;
    logic [31:0]        nxt_base;
    logic               unused_offset;

    // Offset bits of the request address never reach the memory side.
    assign unused_offset = ^dfp_addr_i[OFFSET_W-1:0];

    assign cur_base = 32'(beat_q) * BEAT_W;
    assign nxt_base = 32'(beat_q + CNT_W'(1)) * BEAT_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            beat_q  <= '0;
            line_q  <= '0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        line_d  = line_q;
        rdata_d = rdata_q;
        resp_d  = 1'b0;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        // A beat arriving anywhere but collection is dropped and flagged.
        err_d   = err_q | (bmem_rvalid_i && (state_q != StRdCollect));

        unique case (state_q)
            StIdle: begin
                if (dfp_read_i) begin
                    addr_d  = {dfp_addr_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
                    rd_d    = 1'b1;
                    state_d = StRdCmd;
                end else if (dfp_write_i) begin
                    addr_d  = {dfp_addr_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
                    line_d  = dfp_wdata_i;
                    wdata_d = dfp_wdata_i[BEAT_W-1:0];
                    wr_d    = 1'b1;
                    beat_d  = '0;
                    state_d = StWrBurst;
                end
            end

            StRdCmd: begin
                if (bmem_ready_i) begin
                    rd_d    = 1'b0;
                    beat_d  = '0;
                    state_d = StRdCollect;
                end
            end

            StRdCollect: begin
                if (bmem_rvalid_i) begin
                    line_d[cur_base +: BEAT_W] = bmem_rdata_i;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        rdata_d = line_d;
                        resp_d  = 1'b1;
                        state_d = StResp;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end

            StWrBurst: begin
                if (bmem_ready_i) begin
                    if (beat_q == LAST_BEAT) begin
                        wr_d    = 1'b0;
                        beat_d  = '0;
                        resp_d  = 1'b1;
                        state_d = StResp;
                    end else begin
                        beat_d  = beat_q + CNT_W'(1);
                        wdata_d = line_q[nxt_base +: BEAT_W];
                    end
                end
            end

            StResp: begin
                // resp_q is high for this single cycle; requests are not sampled here.
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign dfp_rdata_o  = rdata_q;
    assign dfp_resp_o   = resp_q;
    assign bmem_addr_o  = addr_q;
    assign bmem_read_o  = rd_q;
    assign bmem_write_o = wr_q;
    assign bmem_wdata_o = wdata_q;
    assign proto_err_o  = err_q;

endmodule
